tone_period_meter: RTL and testbench

Measures the half-period of an incoming square wave and reports it as the counter_top value that would regenerate it on the team's tone oscillator. An oscillator loaded with counter_top = T toggles every T+1 clk cycles; this block recovers T. It sits on the audio/logic-noise input path and is used for pitch detection and oscillator loopback self-test. It also reports lock (stable pitch) and silence (no edges).

---
 rtl/tone_period_meter.sv | 121 ++++++++++++
 tb/tb_tone_period_meter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_period_meter.sv
// Measures the half-period of a square wave and reports it as the oscillator counter_top
// that would regenerate it, along with lock (stable pitch) and silence (no edges) status.
module tone_period_meter #(
    parameter int WIDTH      = 18,
    parameter int TIMEOUT    = 262143,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] top_out,
    output logic             top_valid,
    output logic             locked,
    output logic             silent
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] TOL_V     = WIDTH'(TOL);
    localparam logic [3:0]       LOCK_V    = 4'(LOCK_COUNT);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [WIDTH-1:0] r_gap;
    state_t           r_state;
    logic             r_has_prev;
    logic [3:0]       r_match_cnt;
    logic [WIDTH-1:0] r_top;
    logic             r_top_valid;
    logic             r_locked;
    logic             r_silent;

    logic             w_edge;
    logic             w_gap_sat;
    logic [WIDTH-1:0] w_diff;
    logic             w_match;
    logic [3:0]       w_cnt_inc;

    // Both polarities count: every oscillator toggle is one half-period.
    assign w_edge    = r_s2 ^ r_s3;
    assign w_gap_sat = (r_gap == TIMEOUT_V);
    assign w_diff    = (r_gap > r_top) ? (r_gap - r_top) : (r_top - r_gap);
    assign w_match   = (w_diff <= TOL_V);
    assign w_cnt_inc = (r_match_cnt == LOCK_V) ? r_match_cnt : (r_match_cnt + 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_gap       <= '0;
            r_state     <= ST_IDLE;
            r_has_prev  <= 1'b0;
            r_match_cnt <= '0;
            r_top       <= '0;
            r_top_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_silent    <= 1'b1;
        end else begin
            r_s1        <= sig_in;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_top_valid <= 1'b0;

            // At an edge the gap holds H-1, which is exactly the counter_top to report.
            if (w_edge) begin
                r_gap <= '0;
            end else if (!w_gap_sat) begin
                r_gap <= r_gap + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state    <= ST_MEASURE;
                        r_has_prev <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_edge) begin
                        r_top       <= r_gap;
                        r_top_valid <= 1'b1;
                        r_silent    <= 1'b0;
                        if (!r_has_prev) begin
                            r_has_prev  <= 1'b1;
                            r_match_cnt <= '0;
                        end else if (w_match) begin
                            r_match_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LOCK_V) begin
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_match_cnt <= '0;
                            r_locked    <= 1'b0;
                        end
                    end else if (w_gap_sat) begin
                        r_state     <= ST_IDLE;
                        r_has_prev  <= 1'b0;
                        r_silent    <= 1'b1;
                        r_locked    <= 1'b0;
                        r_match_cnt <= '0;
                        r_top       <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign top_out   = r_top;
    assign top_valid = r_top_valid;
    assign locked    = r_locked;
    assign silent    = r_silent;

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: an edge-timestamp model predicts every output each
// cycle, and literal expectations at key points pin both the model and the design.
module tb_tone_period_meter;

    localparam int WIDTH      = 18;
    localparam int TIMEOUT    = 200;
    localparam int LOCK_COUNT = 4;
    localparam int TOL        = 1;

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic [WIDTH-1:0] top_out;
    logic             top_valid;
    logic             locked;
    logic             silent;

    int checks = 0;
    int errors = 0;

    tone_period_meter #(
        .WIDTH(WIDTH),
        .TIMEOUT(TIMEOUT),
        .LOCK_COUNT(LOCK_COUNT),
        .TOL(TOL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sig_in(sig_in),
        .top_out(top_out),
        .top_valid(top_valid),
        .locked(locked),
        .silent(silent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Works on timestamps of sampled input changes: a change sampled at cycle k is
    // reported at cycle k+2 as (k - previous_change - 1); silence is declared once
    // no change follows within TIMEOUT+1 cycles.
    int cyc;
    int evq[$];
    bit samp_prev;
    bit m_armed;
    bit m_has_prev;
    int m_last;
    int m_top;
    int m_cnt;
    bit m_locked;
    bit m_silent;
    bit m_valid;

    task automatic model_reset();
        evq.delete();
        samp_prev  = 1'b0;
        m_armed    = 1'b0;
        m_has_prev = 1'b0;
        m_last     = 0;
        m_top      = 0;
        m_cnt      = 0;
        m_locked   = 1'b0;
        m_silent   = 1'b1;
        m_valid    = 1'b0;
    endtask

    task automatic model_step();
        int k;
        int meas;
        int diff;
        m_valid = 1'b0;
        if (sig_in != samp_prev) evq.push_back(cyc);
        samp_prev = sig_in;
        if (evq.size() > 0 && evq[0] == cyc - 2) begin
            k = evq.pop_front();
            if (!m_armed) begin
                m_armed    = 1'b1;
                m_has_prev = 1'b0;
                m_last     = k;
            end else begin
                meas    = k - m_last - 1;
                m_last  = k;
                m_valid = 1'b1;
                m_silent = 1'b0;
                if (!m_has_prev) begin
                    m_has_prev = 1'b1;
                    m_cnt      = 0;
                end else begin
                    diff = (meas > m_top) ? meas - m_top : m_top - meas;
                    if (diff <= TOL) begin
                        if (m_cnt < LOCK_COUNT) m_cnt = m_cnt + 1;
                        if (m_cnt == LOCK_COUNT) m_locked = 1'b1;
                    end else begin
                        m_cnt    = 0;
                        m_locked = 1'b0;
                    end
                end
                m_top = meas;
            end
        end else if (m_armed && cyc == m_last + TIMEOUT + 3) begin
            m_armed  = 1'b0;
            m_silent = 1'b1;
            m_locked = 1'b0;
            m_cnt    = 0;
            m_top    = 0;
        end
        cyc = cyc + 1;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("top_out", int'(top_out), m_top);
            check("top_valid", int'(top_valid), int'(m_valid));
            check("locked", int'(locked), int'(m_locked));
            check("silent", int'(silent), int'(m_silent));
        end
    end

    // Toggle the input, then hold it for h cycles; repeat n times.
    task automatic run(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = ~sig_in;
            repeat (h) @(negedge clk);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;

        // Reset held while the input toggles: outputs stay cleared.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sig_in = ~sig_in;
        end
        @(negedge clk);
        check("rst_top", int'(top_out), 0);
        check("rst_silent", int'(silent), 1);
        check("rst_locked", int'(locked), 0);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rel_silent", int'(silent), 1);
        check("rel_valid", int'(top_valid), 0);

        // Basic measurement: half-period 10 -> counter_top 9; 6 matches lock it.
        run(10, 8);
        $display("basic: top_out=%0d silent=%0d locked=%0d", top_out, silent, locked);
        check("basic_top", int'(top_out), 9);
        check("basic_silent", int'(silent), 0);
        check("basic_locked", int'(locked), 1);

        // Lock on 99, tolerate 100/101 alternation.
        run(100, 7);
        $display("lock99: top_out=%0d locked=%0d", top_out, locked);
        check("lock99_top", int'(top_out), 99);
        check("lock99_locked", int'(locked), 1);
        for (int i = 0; i < 3; i++) begin
            run(101, 1);
            run(100, 1);
        end
        $display("alt: top_out=%0d locked=%0d", top_out, locked);
        check("alt_locked", int'(locked), 1);

        // One long half-period breaks lock, then re-lock.
        run(150, 1);
        run(100, 1);
        $display("jump: top_out=%0d locked=%0d", top_out, locked);
        check("jump_top", int'(top_out), 149);
        check("jump_locked", int'(locked), 0);
        run(100, 6);
        $display("relock: top_out=%0d locked=%0d", top_out, locked);
        check("relock_locked", int'(locked), 1);

        // Timeout to silence, then the next edge only re-arms.
        run(20, 5);
        repeat (250) @(negedge clk);
        $display("timeout: top_out=%0d silent=%0d locked=%0d", top_out, silent, locked);
        check("to_silent", int'(silent), 1);
        check("to_top", int'(top_out), 0);
        check("to_locked", int'(locked), 0);
        run(20, 2);
        $display("after_to: top_out=%0d silent=%0d", top_out, silent);
        check("after_to_top", int'(top_out), 19);
        check("after_to_silent", int'(silent), 0);

        // Edge exactly on the saturation cycle is measured; one cycle later is not.
        run(201, 1);
        run(202, 1);
        $display("sat_edge: top_out=%0d silent=%0d", top_out, silent);
        check("sat_top", int'(top_out), TIMEOUT);
        check("sat_silent", int'(silent), 0);
        run(30, 1);
        $display("past_sat: top_out=%0d silent=%0d", top_out, silent);
        check("past_sat_silent", int'(silent), 1);
        check("past_sat_top", int'(top_out), 0);

        // Minimum half-period: toggle every clock.
        run(1, 12);
        repeat (2) @(negedge clk);
        $display("min: top_out=%0d valid=%0d", top_out, top_valid);
        check("min_top", int'(top_out), 0);
        repeat (30) @(negedge clk);

        // Asynchronous reset 5 clocks into a 50-clock half-period.
        if (sig_in == 1'b0) run(50, 1);
        run(50, 2);
        sig_in = ~sig_in;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("async_rst: top_out=%0d valid=%0d silent=%0d locked=%0d",
                 top_out, top_valid, silent, locked);
        check("arst_top", int'(top_out), 0);
        check("arst_valid", int'(top_valid), 0);
        check("arst_silent", int'(silent), 1);
        check("arst_locked", int'(locked), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (45) @(negedge clk);
        check("arst_hold_silent", int'(silent), 1);
        run(50, 3);
        $display("post_rst: top_out=%0d silent=%0d", top_out, silent);
        check("post_rst_top", int'(top_out), 49);
        check("post_rst_silent", int'(silent), 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
